// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution pixel engines.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_BIAS_ACT,
      ST_REQUANT,
      ST_OUTPUT
   } state_e;

   // Wide signed working width for the shared helpers; callers sign-extend into it.
   localparam int WIDE_W = 64;

   localparam int INT8_MIN = -128;
   localparam int INT8_MAX = 127;

   localparam logic signed [WIDE_W-1:0] I8_MIN_W = WIDE_W'(INT8_MIN);
   localparam logic signed [WIDE_W-1:0] I8_MAX_W = WIDE_W'(INT8_MAX);

   // Saturate a wide signed value to int8.
   function automatic logic signed [7:0] clamp_int8(input logic signed [WIDE_W-1:0] v);
      if (v > I8_MAX_W)
         return 8'sd127;
      else if (v < I8_MIN_W)
         return -8'sd128;
      else
         return v[7:0];
   endfunction

   // LeakyReLU with a power-of-two negative slope (arithmetic shift floors toward -inf).
   function automatic logic signed [WIDE_W-1:0] leaky(input logic signed [WIDE_W-1:0] x,
                                                      input int unsigned             sh);
      return x[WIDE_W-1] ? (x >>> sh) : x;
   endfunction

endpackage

// File: rtl/conv_post_lane.sv
// One output channel's post-processing: bias + leaky, then requantize + clamp to int8.
module conv_post_lane
   import conv_pkg::*;
#(
   parameter int          ACC_W       = 32,
   parameter int          SCALE_Q     = 16,
   parameter int unsigned LEAKY_SHIFT = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ld_y,
   input  logic                    ld_q,
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [ACC_W-1:0] bias,
   input  logic        [15:0]      scale,
   output logic signed [7:0]       q_out
);

   localparam int P_W = ACC_W + 17;
   localparam logic signed [P_W-1:0] RND = P_W'(1) <<< (SCALE_Q - 1);

   logic signed [ACC_W-1:0]  x;
   logic signed [ACC_W-1:0]  y_r;
   logic signed [WIDE_W-1:0] y_w;
   logic signed [P_W-1:0]    p;
   logic signed [P_W-1:0]    q;

   // Bias add wraps at ACC_W; saturation happens only at the int8 clamp.
   assign x   = acc + bias;
   assign y_w = leaky(WIDE_W'(x), LEAKY_SHIFT);
   assign p   = P_W'(y_r) * P_W'($signed({1'b0, scale}));
   assign q   = (p + RND) >>> SCALE_Q;

   // Stage 1 captures the activated value, stage 2 the clamped int8 result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_r   <= '0;
         q_out <= '0;
      end else begin
         if (ld_y) y_r   <= ACC_W'(y_w);
         if (ld_q) q_out <= clamp_int8(WIDE_W'(q));
      end
   end

endmodule

// File: rtl/conv1x1_pixel_engine.sv
// Pointwise-convolution pixel engine: NUM_OC parallel MACs over a streamed input-channel
// sequence, followed by per-channel bias/leaky/requant lanes.
module conv1x1_pixel_engine
   import conv_pkg::*;
#(
   parameter int          NUM_OC      = 4,
   parameter int          MAX_IC      = 256,
   parameter int          ACC_W       = 32,
   parameter int          SCALE_Q     = 16,
   parameter int unsigned LEAKY_SHIFT = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [$clog2(MAX_IC+1)-1:0]   num_ic,
   input  logic [NUM_OC*ACC_W-1:0]       bias,
   input  logic [15:0]                   scale,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic signed [7:0]             act,
   input  logic [NUM_OC*8-1:0]           wgt,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_OC*8-1:0]           out_data,
   output logic                          busy
);

   localparam int CNT_W = $clog2(MAX_IC + 1);
   localparam logic [CNT_W-1:0] MAX_IC_C = CNT_W'(MAX_IC);

   state_e                          state;
   logic [CNT_W-1:0]                num_ic_r;
   logic [CNT_W-1:0]                cnt;
   logic [CNT_W-1:0]                num_ic_c;
   logic [NUM_OC*ACC_W-1:0]         bias_r;
   logic [15:0]                     scale_r;
   logic [NUM_OC-1:0][ACC_W-1:0]    acc;
   logic [NUM_OC-1:0][ACC_W-1:0]    prod_ext;
   logic [NUM_OC-1:0][7:0]          q;
   logic                            beat;

   assign in_ready  = (state == ST_ACCUM);
   assign out_valid = (state == ST_OUTPUT);
   assign busy      = (state != ST_IDLE);
   assign beat      = in_valid && in_ready;
   assign num_ic_c  = (num_ic > MAX_IC_C) ? MAX_IC_C : num_ic;
   assign out_data  = q;

   // Per-channel 8x8 signed product, sign-extended to the accumulator width.
   for (genvar k = 0; k < NUM_OC; k++) begin : g_mul
      logic signed [15:0] prod;
      assign prod        = 16'(act) * 16'($signed(wgt[k*8 +: 8]));
      assign prod_ext[k] = ACC_W'(prod);
   end

   // Control FSM, beat counter and MAC accumulators.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         num_ic_r <= '0;
         bias_r   <= '0;
         scale_r  <= '0;
         acc      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  num_ic_r <= num_ic_c;
                  bias_r   <= bias;
                  scale_r  <= scale;
                  cnt      <= '0;
                  acc      <= '0;
                  state    <= (num_ic_c == '0) ? ST_BIAS_ACT : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (beat) begin
                  cnt <= cnt + 1'b1;
                  for (int k = 0; k < NUM_OC; k++)
                     acc[k] <= acc[k] + prod_ext[k];
                  if (cnt + 1'b1 == num_ic_r)
                     state <= ST_BIAS_ACT;
               end
            end
            ST_BIAS_ACT: state <= ST_REQUANT;
            ST_REQUANT:  state <= ST_OUTPUT;
            ST_OUTPUT:   if (out_ready) state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   // One post-processing lane per output channel.
   for (genvar k = 0; k < NUM_OC; k++) begin : g_lane
      conv_post_lane #(
         .ACC_W       (ACC_W),
         .SCALE_Q     (SCALE_Q),
         .LEAKY_SHIFT (LEAKY_SHIFT)
      ) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .ld_y  (state == ST_BIAS_ACT),
         .ld_q  (state == ST_REQUANT),
         .acc   (acc[k]),
         .bias  (bias_r[k*ACC_W +: ACC_W]),
         .scale (scale_r),
         .q_out (q[k])
      );
   end

endmodule
